// File: rtl/vga_plot_pkg.sv
// Shared constants and FSM encoding for the VGA pixel-write arbiter.
// Defaults describe a 160x120, 3-bit colour frame with three requesters.
package vga_plot_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int XW_DEF    = 8;
  localparam int YW_DEF    = 7;
  localparam int CW_DEF    = 3;
  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus: per-requester valid/ready plus packed x/y/colour.
// Requester i occupies slice [i*W +: W] of each packed field.
interface vga_plot_arbiter_if
  import vga_plot_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = CW_DEF
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*XW-1:0] req_x;
  logic [N_REQ*YW-1:0] req_y;
  logic [N_REQ*CW-1:0] req_colour;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin: first asserted request at or after ptr wins.
// The pointer itself lives in the parent so this block stays stateless.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [PW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = PW'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter's single pixel-write port among N_REQ requesters and
// runs a full-frame clear sequencer that pre-empts all of them while active.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = CW_DEF,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  vga_plot_arbiter_if.slave   req_bus,
  input  logic                clear_req,
  input  logic [CW-1:0]       clear_colour,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                clear_done,
  output logic                oob
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [XW-1:0] vga_x_q, vga_x_d;
  logic [YW-1:0] vga_y_q, vga_y_d;
  logic [CW-1:0] vga_colour_q, vga_colour_d;
  logic          vga_plot_q, vga_plot_d;
  logic          clear_done_q, clear_done_d;
  logic          oob_q, oob_d;

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    win;
  logic             any_grant;
  logic [XW-1:0]    win_x;
  logic [YW-1:0]    win_y;
  logic [CW-1:0]    win_colour;
  logic             in_range;
  logic             last_px;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req   (req_bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (win),
    .found (any_grant)
  );

  assign win_x      = req_bus.req_x[int'(win)*XW +: XW];
  assign win_y      = req_bus.req_y[int'(win)*YW +: YW];
  assign win_colour = req_bus.req_colour[int'(win)*CW +: CW];
  assign in_range   = (int'(win_x) < H_RES) && (int'(win_y) < V_RES);
  assign last_px    = (cx_q == XW'(H_RES - 1)) && (cy_q == YW'(V_RES - 1));

  // A pending clear suppresses every grant in the same cycle it is accepted.
  assign req_bus.req_ready = (state_q == IDLE && !clear_req) ? grant : '0;
  assign busy              = (state_q == CLEAR);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    fill_d       = fill_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    clear_done_d = 1'b0;
    oob_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          fill_d  = clear_colour;
          cx_d    = '0;
          cy_d    = '0;
          state_d = CLEAR;
        end else if (any_grant) begin
          vga_x_d      = win_x;
          vga_y_d      = win_y;
          vga_colour_d = win_colour;
          vga_plot_d   = in_range;
          oob_d        = !in_range;
          rr_ptr_d     = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
      end
      CLEAR: begin
        vga_x_d      = cx_q;
        vga_y_d      = cy_q;
        vga_colour_d = fill_q;
        vga_plot_d   = 1'b1;
        if (cx_q == XW'(H_RES - 1)) begin
          cx_d = '0;
          cy_d = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
        if (last_px) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      fill_q       <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      clear_done_q <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      fill_q       <= fill_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      clear_done_q <= clear_done_d;
      oob_q        <= oob_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign clear_done = clear_done_q;
  assign oob        = oob_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus random
// traffic, compared every cycle against a pixel-level reference model.
module tb_vga_plot_arbiter;
  import vga_plot_pkg::*;

  localparam int N  = N_REQ_DEF;
  localparam int XW = XW_DEF;
  localparam int YW = YW_DEF;
  localparam int CW = CW_DEF;
  localparam int H  = H_RES_DEF;
  localparam int V  = V_RES_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic [CW-1:0] clear_colour;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;
  logic          busy;
  logic          clear_done;
  logic          oob;

  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.N_REQ(N), .XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_plot_arbiter dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .req_bus      (bus),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .busy         (busy),
    .clear_done   (clear_done),
    .oob          (oob)
  );

  // Stimulus state
  logic [N-1:0] s_valid;
  int           s_x [N];
  int           s_y [N];
  int           s_c [N];
  logic         s_clear;
  int           s_ccol;
  logic         s_reset;

  // Reference model: clear progress is a linear pixel index, not counters
  int m_ptr;
  bit m_clr;
  int m_pix;
  int m_ccol;
  int e_x, e_y, e_c;
  bit e_plot, e_done, e_oob;

  int checks;
  int failures;
  int plots;
  bit seen;

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      bus.req_x[i*XW +: XW]      = XW'(s_x[i]);
      bus.req_y[i*YW +: YW]      = YW'(s_y[i]);
      bus.req_colour[i*CW +: CW] = CW'(s_c[i]);
    end
    bus.req_valid = s_valid;
    clear_req     = s_clear;
    clear_colour  = CW'(s_ccol);
    reset         = s_reset;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (m_clr || s_clear) return -1;
    for (int k = 0; k < N; k++) begin
      if (s_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic runCycle();
    int           w;
    logic [N-1:0] er;
    #1;
    w  = winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(er));
    checkOutput("busy", 32'(busy), 32'(m_clr));
    if (s_reset) begin
      m_ptr = 0; m_clr = 0; m_pix = 0;
      e_x = 0; e_y = 0; e_c = 0;
      e_plot = 0; e_done = 0; e_oob = 0;
    end else begin
      e_plot = 0; e_done = 0; e_oob = 0;
      if (m_clr) begin
        e_x = m_pix % H;
        e_y = m_pix / H;
        e_c = m_ccol;
        e_plot = 1;
        if (m_pix == H*V - 1) begin
          e_done = 1;
          m_clr  = 0;
        end
        m_pix++;
      end else if (s_clear) begin
        m_clr  = 1;
        m_pix  = 0;
        m_ccol = s_ccol;
      end else if (w >= 0) begin
        e_x = s_x[w];
        e_y = s_y[w];
        e_c = s_c[w];
        if (s_x[w] < H && s_y[w] < V) e_plot = 1;
        else e_oob = 1;
        m_ptr = (w + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("vga_x", 32'(vga_x), 32'(e_x));
    checkOutput("vga_y", 32'(vga_y), 32'(e_y));
    checkOutput("vga_colour", 32'(vga_colour), 32'(e_c));
    checkOutput("vga_plot", 32'(vga_plot), 32'(e_plot));
    checkOutput("clear_done", 32'(clear_done), 32'(e_done));
    checkOutput("oob", 32'(oob), 32'(e_oob));
  endtask

  initial begin
    checks = 0; failures = 0;
    s_valid = '0; s_clear = 1'b0; s_ccol = 0; s_reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_x[i] = 0; s_y[i] = 0; s_c[i] = 0;
    end
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    m_ptr = 0; m_clr = 0; m_pix = 0; m_ccol = 0;
    runCycle();
    s_reset = 1'b0;
    applyStimulus();

    // Idle with no requesters
    repeat (20) runCycle();

    // Single request from requester 0
    s_valid = 3'b001; s_x[0] = 4; s_y[0] = 4; s_c[0] = 4;
    applyStimulus();
    runCycle();
    checkOutput("t2_pixel", {28'(0), vga_plot, 3'(0)} | 32'({vga_x, vga_y, vga_colour}) << 4,
                (32'(1) << 3) | (32'({8'd4, 7'd4, 3'b100}) << 4));
    s_valid = '0;
    applyStimulus();
    runCycle();
    checkOutput("t2_plot_off", 32'(vga_plot), 32'(0));

    // Fairness with all requesters permanently valid
    s_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        s_x[i] = 10*c + i; s_y[i] = 20 + c; s_c[i] = (c + i) % 8;
      end
      applyStimulus();
      runCycle();
    end

    // Full clear with a competing request from requester 1
    s_valid = 3'b010; s_x[1] = 30; s_y[1] = 40; s_c[1] = 6;
    s_clear = 1'b1; s_ccol = 0;
    applyStimulus();
    runCycle();
    s_clear = 1'b0;
    applyStimulus();
    plots = 0; seen = 0;
    for (int k = 0; k < 19300 && !seen; k++) begin
      runCycle();
      if (vga_plot) plots++;
      if (clear_done) seen = 1;
    end
    checkOutput("t4_done_seen", 32'(seen), 32'(1));
    checkOutput("t4_plot_count", 32'(plots), 32'(H*V));
    runCycle();
    s_valid = '0;
    applyStimulus();
    runCycle();

    // Out-of-range pixels are consumed but not plotted
    s_valid = 3'b100; s_x[2] = 160; s_y[2] = 5; s_c[2] = 1;
    applyStimulus();
    runCycle();
    checkOutput("t5_oob_x", 32'({vga_plot, oob}), 32'(2'b01));
    s_x[2] = 3; s_y[2] = 120;
    applyStimulus();
    runCycle();
    checkOutput("t5_oob_y", 32'({vga_plot, oob}), 32'(2'b01));
    s_valid = '0;
    applyStimulus();
    runCycle();

    // Reset partway through a clear
    s_clear = 1'b1; s_ccol = 5;
    applyStimulus();
    runCycle();
    s_clear = 1'b0;
    applyStimulus();
    plots = 0;
    for (int k = 0; k < 600 && plots < 500; k++) begin
      runCycle();
      if (vga_plot) plots++;
    end
    checkOutput("t6_reach_500", 32'(plots), 32'(500));
    s_reset = 1'b1;
    applyStimulus();
    runCycle();
    s_reset = 1'b0;
    applyStimulus();
    checkOutput("t6_plot", 32'(vga_plot), 32'(0));
    checkOutput("t6_busy", 32'(busy), 32'(0));
    s_valid = 3'b011; s_x[0] = 7; s_y[0] = 8; s_c[0] = 2; s_x[1] = 9; s_y[1] = 10; s_c[1] = 3;
    applyStimulus();
    runCycle();
    checkOutput("t6_rr_from_0", 32'(vga_x), 32'(7));
    s_valid = '0;
    applyStimulus();
    runCycle();

    // Random traffic
    repeat (400) begin
      s_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        s_x[i] = int'($urandom_range(0, 175));
        s_y[i] = int'($urandom_range(0, 127));
        s_c[i] = int'($urandom_range(0, 7));
      end
      applyStimulus();
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
